// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline bundle: execute-stage results, stall/flush control,
// and the registered MEM-side copies plus the MADD/MSUB state loop-back.
interface ex_mem_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STALL_W    = 6
);
    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic                  ex_enhilo;
    logic [2*DATA_W-1:0]   hilo_temp_i;
    logic [1:0]            cnt_i;
    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic                  mem_enhilo;
    logic [2*DATA_W-1:0]   hilo_temp_o;
    logic [1:0]            cnt_o;

    // Pipeline control / EX side: drives EX results and stall/flush.
    modport master (
        output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
               ex_enhilo, hilo_temp_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo,
               hilo_temp_o, cnt_o
    );

    // The pipeline register itself.
    modport slave (
        input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
               ex_enhilo, hilo_temp_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_enhilo,
               hilo_temp_o, cnt_o
    );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the MIPS32 pipeline. Inserts bubbles or holds on
// stall, clears on flush, and loops MADD/MSUB progress back to EX.
module ex_mem #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int STALL_W    = 6
) (
    input  logic    clk,
    input  logic    rst,
    ex_mem_if.slave bus
);
    logic [REG_ADDR_W-1:0] r_mem_wd;
    logic                  r_mem_wreg;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_mem_hi;
    logic [DATA_W-1:0]     r_mem_lo;
    logic                  r_mem_enhilo;
    logic [2*DATA_W-1:0]   r_hilo_temp;
    logic [1:0]            r_cnt;
    logic [1:0]            w_stall_ex_mem;

    assign w_stall_ex_mem = {bus.stall[3], bus.stall[4]};

    // Pipeline register update: rst > flush > stall decode.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_mem_wd     <= {REG_ADDR_W{1'b0}};
            r_mem_wreg   <= 1'b0;
            r_mem_wdata  <= {DATA_W{1'b0}};
            r_mem_hi     <= {DATA_W{1'b0}};
            r_mem_lo     <= {DATA_W{1'b0}};
            r_mem_enhilo <= 1'b0;
            r_hilo_temp  <= {(2*DATA_W){1'b0}};
            r_cnt        <= 2'd0;
        end else begin
            case (w_stall_ex_mem)
                2'b00: begin
                    r_mem_wd     <= bus.ex_wd;
                    r_mem_wreg   <= bus.ex_wreg;
                    r_mem_wdata  <= bus.ex_wdata;
                    r_mem_hi     <= bus.ex_hi;
                    r_mem_lo     <= bus.ex_lo;
                    r_mem_enhilo <= bus.ex_enhilo;
                    r_hilo_temp  <= {(2*DATA_W){1'b0}};
                    r_cnt        <= 2'd0;
                end
                // EX stalled, MEM free: send a NOP but keep MADD/MSUB progress.
                2'b10: begin
                    r_mem_wd     <= {REG_ADDR_W{1'b0}};
                    r_mem_wreg   <= 1'b0;
                    r_mem_wdata  <= {DATA_W{1'b0}};
                    r_mem_hi     <= {DATA_W{1'b0}};
                    r_mem_lo     <= {DATA_W{1'b0}};
                    r_mem_enhilo <= 1'b0;
                    r_hilo_temp  <= bus.hilo_temp_i;
                    r_cnt        <= bus.cnt_i;
                end
                2'b11: begin
                    r_mem_wd     <= r_mem_wd;
                    r_mem_wreg   <= r_mem_wreg;
                    r_mem_wdata  <= r_mem_wdata;
                    r_mem_hi     <= r_mem_hi;
                    r_mem_lo     <= r_mem_lo;
                    r_mem_enhilo <= r_mem_enhilo;
                    r_hilo_temp  <= bus.hilo_temp_i;
                    r_cnt        <= bus.cnt_i;
                end
                // Downstream stalled with upstream running: freeze everything.
                default: begin
                    r_mem_wd     <= r_mem_wd;
                    r_mem_wreg   <= r_mem_wreg;
                    r_mem_wdata  <= r_mem_wdata;
                    r_mem_hi     <= r_mem_hi;
                    r_mem_lo     <= r_mem_lo;
                    r_mem_enhilo <= r_mem_enhilo;
                    r_hilo_temp  <= r_hilo_temp;
                    r_cnt        <= r_cnt;
                end
            endcase
        end
    end

    assign bus.mem_wd      = r_mem_wd;
    assign bus.mem_wreg    = r_mem_wreg;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_hi      = r_mem_hi;
    assign bus.mem_lo      = r_mem_lo;
    assign bus.mem_enhilo  = r_mem_enhilo;
    assign bus.hilo_temp_o = r_hilo_temp;
    assign bus.cnt_o       = r_cnt;
endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the combinational memory stage of the 5-stage MIPS32 pipeline.
- Captures EX results (register write-back and HI/LO write) on each clock and presents them to the memory stage.
- Supports stall bubbles and a flush.
- Carries the 2-cycle multiply-accumulate state (hilo_temp, cnt) back to EX so that MADD/MSUB survive a stall.

Parameters:
- DATA_W, 32, width of data words and HI/LO.
- REG_ADDR_W, 5, width of the GPR write address.
- STALL_W, 6, width of the pipeline stall vector. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  stall vector from the pipeline control unit; this block uses bits 3 and 4.
- flush  in  1  synchronous pipeline flush (exception/eret).
- ex_wd  in  REG_ADDR_W  destination GPR address from EX.
- ex_wreg  in  1  GPR write enable from EX.
- ex_wdata  in  DATA_W  GPR write data from EX.
- ex_hi  in  DATA_W  HI write value from EX.
- ex_lo  in  DATA_W  LO write value from EX.
- ex_enhilo  in  1  HI/LO write enable from EX.
- hilo_temp_i  in  2*DATA_W  partial MADD/MSUB product from EX.
- cnt_i  in  2  MADD/MSUB cycle counter from EX.
- mem_wd  out  REG_ADDR_W  registered destination address to MEM.
- mem_wreg  out  1  registered GPR write enable.
- mem_wdata  out  DATA_W  registered GPR write data.
- mem_hi  out  DATA_W  registered HI value.
- mem_lo  out  DATA_W  registered LO value.
- mem_enhilo  out  1  registered HI/LO write enable.
- hilo_temp_o  out  2*DATA_W  registered partial product returned to EX.
- cnt_o  out  2  registered cycle counter returned to EX.

Behaviour:
- Clock and reset:
  - One clock domain, rising edge.
  - Reset is synchronous and active-high, sampled on the rising edge.
  - Every output is a flop; there is no combinational input-to-output path.
- Reset values: every output is zero.
  - mem_wd = 0 (NOP address), mem_wreg = 0, mem_wdata = 0.
  - mem_hi = 0, mem_lo = 0, mem_enhilo = 0.
  - hilo_temp_o = 0, cnt_o = 0.
- Priority per edge: rst > flush > stall decode.
- flush = 1: same values as reset on all outputs, including hilo_temp_o and cnt_o. This aborts any in-progress MADD/MSUB.
- Stall decode, with s3 = stall[3] and s4 = stall[4]:
  - s3 = 0, s4 = 0 (advance):
    - All mem_* outputs load their ex_* inputs.
    - hilo_temp_o = 0, cnt_o = 0.
    - Latency is exactly 1 cycle from ex_* to mem_*.
  - s3 = 1, s4 = 0 (bubble):
    - mem_* outputs are loaded with the NOP values (all zero, both enables 0).
    - hilo_temp_o loads hilo_temp_i; cnt_o loads cnt_i. This preserves MADD/MSUB progress across the EX stall.
  - s3 = 1, s4 = 1 (hold):
    - All mem_* outputs keep their previous value.
    - hilo_temp_o loads hilo_temp_i; cnt_o loads cnt_i.
  - s3 = 0, s4 = 1 (illegal: downstream stalled, upstream not):
    - All outputs hold, including hilo_temp_o and cnt_o.
    - The verification bench flags this pattern as an assertion failure.
- Stall bits other than 3 and 4 are ignored.
- No arithmetic is performed; widths pass through unchanged.
- A flush arriving in the same cycle as any stall pattern wins.
- Reset deasserted mid-MADD: the accumulation restarts from cnt = 0.

Test Plan:
- Reset: drive rst = 1 for 2 cycles with ex_wdata = 32'hDEADBEEF, ex_wreg = 1 -> all outputs 0 throughout. First edge after rst = 0 with stall = 0 -> mem_wdata = 32'hDEADBEEF, mem_wreg = 1, mem_wd = ex_wd.
- Streaming: stall = 0; ex_wd = 5,6,7 on consecutive cycles with ex_wdata = 1,2,3 -> mem_wd/mem_wdata show 5/1, 6/2, 7/3, each one cycle later. hilo_temp_o = 0 and cnt_o = 0 throughout.
- Bubble with MADD: stall = 6'b001111, hilo_temp_i = 64'h0000_0001_0000_0002, cnt_i = 1 -> after the edge mem_wreg = 0, mem_enhilo = 0, mem_wd = 0, hilo_temp_o = 64'h0000_0001_0000_0002, cnt_o = 1. Next cycle stall = 0, ex_enhilo = 1, ex_hi = 32'h5 -> mem_hi = 5, mem_enhilo = 1, cnt_o = 0.
- Hold: load mem_wdata = 32'hA5A5A5A5, then stall = 6'b011111 for 3 cycles with varying ex_* -> mem_wdata stays 32'hA5A5A5A5. hilo_temp_o follows hilo_temp_i each cycle.
- Flush priority: flush = 1 together with stall = 6'b011111 and nonzero hilo_temp_i/cnt_i = 2 -> all outputs 0 after the edge.
- Illegal stall: stall = 6'b010000 -> all outputs unchanged, and the bench assertion fires.
